// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the core's load/store port.
// Accepts one request, waits WAIT_STATES cycles, performs the access, and returns one response.
module dmem_responder #(
    parameter int MEM_SIZE_DATA = 1024,
    parameter int WAIT_STATES   = 2,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [DATA_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [2:0]            req_funct3_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o
);

    localparam int IDX_W = (MEM_SIZE_DATA > 1) ? $clog2(MEM_SIZE_DATA) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                  state;
    logic [3:0]              count;
    logic                    lat_we;
    logic [DATA_WIDTH-1:0]   lat_addr;
    logic [DATA_WIDTH-1:0]   lat_wdata;
    logic [2:0]              lat_f3;

    logic [31:0]             mem [MEM_SIZE_DATA];

    logic [1:0]              size;
    logic                    illegal;
    logic                    misaligned;
    logic                    out_of_range;
    logic                    err;
    logic [IDX_W-1:0]        idx;
    logic [31:0]             rd_word;
    logic [7:0]              rd_byte;
    logic [15:0]             rd_half;
    logic                    sext;
    logic [31:0]             load_data;
    logic [3:0]              be;
    logic [31:0]             wlane;
    logic                    access;
    logic                    do_write;

    assign req_ready_o = (state == S_IDLE) && !rst_i;

    // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        size         = lat_f3[1:0];
        illegal      = 1'b0;
        misaligned   = 1'b0;
        out_of_range = 1'b0;
        err          = 1'b0;
        idx          = lat_addr[IDX_W+1:2];
        rd_word      = mem[idx];
        rd_byte      = rd_word[{lat_addr[1:0], 3'b000} +: 8];
        rd_half      = lat_addr[1] ? rd_word[31:16] : rd_word[15:0];
        sext         = !lat_f3[2];
        load_data    = rd_word;
        be           = 4'b1111;
        wlane        = lat_wdata;
        access       = 1'b0;
        do_write     = 1'b0;

        // Loads allow 0,1,2,4,5; stores allow only 0,1,2.
        if (lat_we) begin
            illegal = (lat_f3 > 3'd2);
        end else begin
            illegal = (lat_f3 == 3'd3) || (lat_f3[2:1] == 2'b11);
        end
        misaligned   = ((size == 2'd1) && lat_addr[0]) ||
                       ((size == 2'd2) && (lat_addr[1:0] != 2'b00));
        out_of_range = ({2'b00, lat_addr[31:2]} >= 32'(MEM_SIZE_DATA));
        err          = illegal || misaligned || out_of_range;

        case (size)
            2'd0: begin
                load_data = {{24{rd_byte[7] & sext}}, rd_byte};
                be        = 4'b0001 << lat_addr[1:0];
                wlane     = {4{lat_wdata[7:0]}};
            end
            2'd1: begin
                load_data = {{16{rd_half[15] & sext}}, rd_half};
                be        = lat_addr[1] ? 4'b1100 : 4'b0011;
                wlane     = {2{lat_wdata[15:0]}};
            end
            default: begin
                load_data = rd_word;
                be        = 4'b1111;
                wlane     = lat_wdata;
            end
        endcase

        access   = (state == S_WAIT) && (count == 4'd0);
        do_write = access && lat_we && !err;
    end

    // NOTE: storage is deliberately left out of reset; only the control path is reset.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (do_write && be[b]) begin
                mem[idx][8*b +: 8] <= wlane[8*b +: 8];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            count       <= 4'd0;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            lat_f3      <= 3'd0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        lat_we    <= req_we_i;
                        lat_addr  <= req_addr_i;
                        lat_wdata <= req_wdata_i;
                        lat_f3    <= req_funct3_i;
                        count     <= 4'(WAIT_STATES);
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (count != 4'd0) begin
                        count <= count - 4'd1;
                    end else begin
                        state       <= S_RESP;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= err;
                        rsp_rdata_o <= (err || lat_we) ? '0 : load_data;
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        state       <= S_IDLE;
                        rsp_valid_o <= 1'b0;
                        rsp_rdata_o <= '0;
                        rsp_err_o   <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a byte-addressed reference model checked every cycle,
// plus directed transactions with hand-computed expected results.
module tb_dmem_responder;

    localparam int MEM = 1024;
    localparam int WS  = 2;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [2:0]  req_funct3_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;

    int n_pass  = 0;
    int n_total = 0;
    bit cmp_en  = 1'b0;

    always #5 clk = ~clk;

    dmem_responder #(
        .MEM_SIZE_DATA(MEM),
        .WAIT_STATES  (WS),
        .DATA_WIDTH   (32)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_funct3_i(req_funct3_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference model: byte-addressed memory plus the pending request and its age in cycles.
    logic [7:0]  mb [0:4*MEM-1];
    bit          pending = 1'b0;
    int          age = 0;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [2:0]  m_f3;
    logic [31:0] m_rdata = '0;
    logic        m_err = 1'b0;

    function automatic bit model_err(input logic we, input logic [31:0] addr, input logic [2:0] f3);
        bit          legal;
        int unsigned n;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        n     = 32'd1 << f3[1:0];
        return !legal || ((addr & (n - 1)) != 0) || ((addr >> 2) >= MEM);
    endfunction

    always @(posedge clk) begin
        if (rst_i) begin
            pending = 1'b0;
        end else if (pending) begin
            if (age >= WS + 1) begin
                if (rsp_ready_i) pending = 1'b0;
            end else begin
                if (age == WS) begin
                    int          n;
                    logic [31:0] val;
                    m_err   = model_err(m_we, m_addr, m_f3);
                    m_rdata = '0;
                    if (!m_err) begin
                        n = 1 << m_f3[1:0];
                        if (m_we) begin
                            for (int i = 0; i < n; i++) mb[int'(m_addr) + i] = m_wdata[8*i +: 8];
                        end else begin
                            val = '0;
                            for (int i = 0; i < n; i++) val = val | (32'(mb[int'(m_addr) + i]) << (8*i));
                            if (!m_f3[2] && n < 4 && val[8*n-1]) val = val | (~32'd0 << (8*n));
                            m_rdata = val;
                        end
                    end
                end
                age++;
            end
        end else if (req_valid_i) begin
            m_we    = req_we_i;
            m_addr  = req_addr_i;
            m_wdata = req_wdata_i;
            m_f3    = req_funct3_i;
            pending = 1'b1;
            age     = 0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            logic exp_valid;
            exp_valid = !rst_i && pending && (age >= WS + 1);
            check("cyc_req_ready", 32'(req_ready_o), 32'(!rst_i && !pending));
            check("cyc_rsp_valid", 32'(rsp_valid_o), 32'(exp_valid));
            check("cyc_rsp_rdata", rsp_rdata_o, exp_valid ? m_rdata : 32'd0);
            check("cyc_rsp_err",   32'(rsp_err_o), exp_valid ? 32'(m_err) : 32'd0);
        end
    end

    // hold < 0 keeps rsp_ready_i high for the whole transaction.
    task automatic txn(input string name, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] f3,
                       input logic [31:0] exp_rdata, input logic exp_err, input int hold);
        int n;
        int lat;
        @(negedge clk);
        n = 0;
        while (!req_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({name, "_ready_wait"}, 32'(req_ready_o), 32'd1);
        #1;
        req_valid_i  = 1'b1;
        req_we_i     = we;
        req_addr_i   = addr;
        req_wdata_i  = wdata;
        req_funct3_i = f3;
        if (hold < 0) rsp_ready_i = 1'b1;
        @(posedge clk);
        #1;
        req_valid_i  = 1'b0;
        req_we_i     = ~we;
        req_addr_i   = 32'hFFFF_FFFC;
        req_wdata_i  = 32'h0BAD_0BAD;
        req_funct3_i = 3'd7;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            #1;
        end while (!rsp_valid_o && lat < 40);
        check({name, "_latency"}, 32'(lat), 32'(WS + 1));
        check({name, "_rdata"}, rsp_rdata_o, exp_rdata);
        check({name, "_err"}, 32'(rsp_err_o), 32'(exp_err));
        if (hold >= 0) begin
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                check({name, "_bp_valid"}, 32'(rsp_valid_o), 32'd1);
                check({name, "_bp_rdata"}, rsp_rdata_o, exp_rdata);
                check({name, "_bp_err"}, 32'(rsp_err_o), 32'(exp_err));
                check({name, "_bp_req_ready"}, 32'(req_ready_o), 32'd0);
            end
            rsp_ready_i = 1'b1;
        end
        @(posedge clk);
        #1;
        rsp_ready_i = 1'b0;
        check({name, "_done_valid"}, 32'(rsp_valid_o), 32'd0);
        check({name, "_done_ready"}, 32'(req_ready_o), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i        = 1'b1;
        req_valid_i  = 1'b0;
        req_we_i     = 1'b0;
        req_addr_i   = '0;
        req_wdata_i  = '0;
        req_funct3_i = 3'd0;
        rsp_ready_i  = 1'b0;
        @(posedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready_o), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_rsp_rdata", rsp_rdata_o, 32'd0);
        repeat (2) @(negedge clk);
        #1;
        rst_i = 1'b0;
        #1;
        check("post_rst_ready", 32'(req_ready_o), 32'd1);

        // Write then read
        txn("sw_10", 1'b1, 32'h10, 32'hDEAD_BEEF, 3'd2, 32'h0, 1'b0, 0);
        txn("lw_10", 1'b0, 32'h10, 32'h0,         3'd2, 32'hDEAD_BEEF, 1'b0, 0);

        // Byte-lane stores; upper wdata bits must be ignored for SB/SH
        txn("sw_20", 1'b1, 32'h20, 32'h0000_0000, 3'd2, 32'h0, 1'b0, 0);
        txn("sb_21", 1'b1, 32'h21, 32'h7777_77AB, 3'd0, 32'h0, 1'b0, 0);
        txn("sh_22", 1'b1, 32'h22, 32'h5555_1234, 3'd1, 32'h0, 1'b0, 0);
        txn("lw_20", 1'b0, 32'h20, 32'h0,         3'd2, 32'h1234_AB00, 1'b0, 0);

        // Sign and zero extension
        txn("sw_30",  1'b1, 32'h30, 32'h0000_F080, 3'd2, 32'h0, 1'b0, 0);
        txn("lb_30",  1'b0, 32'h30, 32'h0, 3'd0, 32'hFFFF_FF80, 1'b0, 0);
        txn("lbu_30", 1'b0, 32'h30, 32'h0, 3'd4, 32'h0000_0080, 1'b0, 0);
        txn("lh_30",  1'b0, 32'h30, 32'h0, 3'd1, 32'hFFFF_F080, 1'b0, 0);
        txn("lhu_30", 1'b0, 32'h30, 32'h0, 3'd5, 32'h0000_F080, 1'b0, 0);
        txn("lb_31",  1'b0, 32'h31, 32'h0, 3'd0, 32'hFFFF_FFF0, 1'b0, 0);

        // Error cases
        txn("lh_31_mis",  1'b0, 32'h31, 32'h0, 3'd1, 32'h0, 1'b1, 0);
        txn("sw_32_mis",  1'b1, 32'h32, 32'hFFFF_FFFF, 3'd2, 32'h0, 1'b1, 0);
        txn("lw_30_keep", 1'b0, 32'h30, 32'h0, 3'd2, 32'h0000_F080, 1'b0, 0);
        txn("lw_oor",     1'b0, 32'(4*MEM), 32'h0, 3'd2, 32'h0, 1'b1, 0);
        txn("ld_f3_3",    1'b0, 32'h30, 32'h0, 3'd3, 32'h0, 1'b1, 0);
        txn("st_f3_4",    1'b1, 32'h20, 32'hFFFF_FFFF, 3'd4, 32'h0, 1'b1, 0);

        // Backpressure, then ready held high (one-cycle response)
        txn("lw_10_bp",  1'b0, 32'h10, 32'h0, 3'd2, 32'hDEAD_BEEF, 1'b0, 5);
        txn("lw_20_rdy", 1'b0, 32'h20, 32'h0, 3'd2, 32'h1234_AB00, 1'b0, -1);

        // Reset in the middle of a store's wait states
        txn("sw_40", 1'b1, 32'h40, 32'h1122_3344, 3'd2, 32'h0, 1'b0, 0);
        @(negedge clk);
        #1;
        req_valid_i  = 1'b1;
        req_we_i     = 1'b1;
        req_addr_i   = 32'h40;
        req_wdata_i  = 32'h55AA_55AA;
        req_funct3_i = 3'd2;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        #1;
        check("midrst_valid", 32'(rsp_valid_o), 32'd0);
        check("midrst_ready", 32'(req_ready_o), 32'd0);
        repeat (2) @(negedge clk);
        #1;
        rst_i = 1'b0;
        txn("lw_40_after_rst", 1'b0, 32'h40, 32'h0, 3'd2, 32'h1122_3344, 1'b0, 0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
